// File: rtl/weight_load_responder.sv
// Weight-load responder: on weight_req, streams one filter group into the weight BRAM banks, then acks.
// Optional WEIGHT_PINGPONG_EN alternates the load base between bank halves and adds active_half.
module weight_load_responder #(
  parameter int unsigned DW             = 16,
  parameter int unsigned Dimension      = 16,
  parameter int unsigned ADDRESS_LENGTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      weight_req,
  output logic                      weight_ack,
  input  logic [4:0]                kernel_size,
  input  logic [9:0]                input_channels,
  input  logic [DW-1:0]             s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [Dimension-1:0]      wea_weight,
  output logic [ADDRESS_LENGTH-1:0] addr_weight,
  output logic [DW-1:0]             din_weight,
  output logic                      busy,
  output logic                      err_len
`ifdef WEIGHT_PINGPONG_EN
  ,
  output logic                      active_half
`endif
);

  localparam int unsigned LEN_W  = 15;
  localparam int unsigned BANK_W = (Dimension > 1) ? $clog2(Dimension) : 1;
  localparam int unsigned BEAT_W = LEN_W + BANK_W;
`ifdef WEIGHT_PINGPONG_EN
  localparam int unsigned LEN_LIMIT = 1 << (ADDRESS_LENGTH - 1);
`else
  localparam int unsigned LEN_LIMIT = 1 << ADDRESS_LENGTH;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, ACK, WAIT_LOW} state_t;

  state_t                    state, state_n;
  logic [LEN_W-1:0]          len_q, len_n;
  logic [BANK_W-1:0]         bank_cnt, bank_n;
  logic [ADDRESS_LENGTH-1:0] addr_cnt, addr_cnt_n;
  logic [BEAT_W-1:0]         beat_cnt, beat_n;
  logic                      ack_n, ready_n, busy_n, err_n;
  logic [Dimension-1:0]      wea_n;
  logic [ADDRESS_LENGTH-1:0] addr_n;
  logic [DW-1:0]             din_n;
  logic [ADDRESS_LENGTH-1:0] base_c;
  logic [LEN_W-1:0]          len_c;
  logic [BEAT_W-1:0]         last_beat_c;
  logic                      beat_c;

  assign len_c       = LEN_W'(kernel_size) * LEN_W'(input_channels);
  assign last_beat_c = BEAT_W'(len_q) * BEAT_W'(Dimension) - BEAT_W'(1);
  assign beat_c      = (state == LOAD) && s_valid && s_ready;

`ifdef WEIGHT_PINGPONG_EN
  logic half_q, half_n, active_n;
  assign base_c = ADDRESS_LENGTH'(half_q) << (ADDRESS_LENGTH - 1);
`else
  assign base_c = '0;
`endif

  // Next state, counters and next values of every registered output
  always_comb begin
    state_n    = state;
    len_n      = len_q;
    bank_n     = bank_cnt;
    addr_cnt_n = addr_cnt;
    beat_n     = beat_cnt;
    wea_n      = '0;
    addr_n     = addr_weight;
    din_n      = din_weight;
    err_n      = err_len;
`ifdef WEIGHT_PINGPONG_EN
    half_n     = half_q;
    active_n   = active_half;
`endif
    case (state)
      IDLE: begin
        if (weight_req) begin
          if (len_c == '0) begin
            state_n = ACK;
            err_n   = 1'b0;
          end else if (32'(len_c) > LEN_LIMIT) begin
            state_n = ACK;
            err_n   = 1'b1;
          end else begin
            state_n    = LOAD;
            err_n      = 1'b0;
            len_n      = len_c;
            bank_n     = '0;
            addr_cnt_n = '0;
            beat_n     = '0;
          end
        end
      end
      LOAD: begin
        if (beat_c) begin
          wea_n  = Dimension'(1) << bank_cnt;
          addr_n = base_c | addr_cnt;
          din_n  = s_data;
          beat_n = beat_cnt + BEAT_W'(1);
          if (bank_cnt == BANK_W'(Dimension - 1)) begin
            bank_n     = '0;
            addr_cnt_n = addr_cnt + ADDRESS_LENGTH'(1);
          end else begin
            bank_n = bank_cnt + BANK_W'(1);
          end
          if (beat_cnt == last_beat_c) state_n = FLUSH;
        end
      end
      FLUSH: begin
        state_n = ACK;
`ifdef WEIGHT_PINGPONG_EN
        active_n = half_q;
        half_n   = ~half_q;
`endif
      end
      ACK:      state_n = WAIT_LOW;
      WAIT_LOW: if (!weight_req) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    ack_n   = (state_n == ACK);
    ready_n = (state_n == LOAD);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      bank_cnt    <= '0;
      addr_cnt    <= '0;
      beat_cnt    <= '0;
      weight_ack  <= 1'b0;
      s_ready     <= 1'b0;
      wea_weight  <= '0;
      addr_weight <= '0;
      din_weight  <= '0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
`ifdef WEIGHT_PINGPONG_EN
      half_q      <= 1'b0;
      active_half <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      len_q       <= len_n;
      bank_cnt    <= bank_n;
      addr_cnt    <= addr_cnt_n;
      beat_cnt    <= beat_n;
      weight_ack  <= ack_n;
      s_ready     <= ready_n;
      wea_weight  <= wea_n;
      addr_weight <= addr_n;
      din_weight  <= din_n;
      busy        <= busy_n;
      err_len     <= err_n;
`ifdef WEIGHT_PINGPONG_EN
      half_q      <= half_n;
      active_half <= active_n;
`endif
    end
  end

endmodule

// File: tb/tb_weight_load_responder.sv
// Randomized self-checking bench for weight_load_responder against a transaction-level model.
// Build with WEIGHT_PINGPONG_EN defined to exercise the half-swapping variant.
module tb_weight_load_responder;

  localparam int unsigned DW  = 16;
  localparam int unsigned DIM = 16;
  localparam int unsigned AW  = 10;
`ifdef WEIGHT_PINGPONG_EN
  localparam int LIMIT     = 512;
  localparam int HALF_BASE = 512;
`else
  localparam int LIMIT     = 1024;
  localparam int HALF_BASE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          weight_req = 1'b0;
  logic          weight_ack;
  logic [4:0]    kernel_size = '0;
  logic [9:0]    input_channels = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DIM-1:0] wea_weight;
  logic [AW-1:0] addr_weight;
  logic [DW-1:0] din_weight;
  logic          busy;
  logic          err_len;
`ifdef WEIGHT_PINGPONG_EN
  logic          active_half;
`endif

  always #5 clk = ~clk;

  weight_load_responder #(.DW(DW), .Dimension(DIM), .ADDRESS_LENGTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .weight_req(weight_req), .weight_ack(weight_ack),
    .kernel_size(kernel_size), .input_channels(input_channels),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wea_weight(wea_weight), .addr_weight(addr_weight), .din_weight(din_weight),
    .busy(busy), .err_len(err_len)
`ifdef WEIGHT_PINGPONG_EN
    , .active_half(active_half)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int ack_cyc = 0;
  int wr_count = 0;
  int ack_count = 0;
  int rdy_count = 0;
  logic [DW-1:0] dut_mem [0:DIM-1][0:(1<<AW)-1];

  // Transaction-level model: phase flags plus beat bookkeeping
  bit  m_idle, m_loading, m_waitlow, m_err, m_pend;
  int  m_total, m_done, m_ack_at, m_half, m_active;
  logic [DIM-1:0] e_wea;
  logic [AW-1:0]  e_addr;
  logic [DW-1:0]  e_din;
  bit  e_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_loading = 0; m_waitlow = 0; m_err = 0; m_pend = 0;
    m_total = 0; m_done = 0; m_ack_at = -1; m_half = 0; m_active = 0;
    e_wea = '0; e_addr = '0; e_din = '0; e_ack = 0;
  endtask

  task automatic model_step();
    int i, len;
    bit was_idle;
    cyc++;
    was_idle = m_idle;
    e_wea = '0;
    e_ack = 0;
    if (m_waitlow && !weight_req) begin
      m_waitlow = 0;
      m_idle    = 1;
    end else if (m_ack_at >= 0 && cyc == m_ack_at + 1) begin
      m_waitlow = 1;
      m_ack_at  = -1;
    end
    if (m_loading && s_valid) begin
      i      = m_done;
      e_wea  = DIM'(1) << (i % DIM);
      e_addr = AW'(m_half * HALF_BASE + i / DIM);
      e_din  = s_data;
      m_done++;
      if (m_done == m_total) begin
        m_loading = 0;
        m_ack_at  = cyc + 1;
        m_pend    = 1;
      end
    end else if (was_idle && weight_req) begin
      len    = int'(kernel_size) * int'(input_channels);
      m_idle = 0;
      if (len == 0) begin
        m_err = 0; m_ack_at = cyc;
      end else if (len > LIMIT) begin
        m_err = 1; m_ack_at = cyc;
      end else begin
        m_err = 0; m_loading = 1; m_total = len * DIM; m_done = 0;
      end
    end
    if (cyc == m_ack_at) begin
      e_ack = 1;
      if (m_pend) begin
        m_active = m_half;
        m_half   = 1 - m_half;
        m_pend   = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every out-of-reset cycle, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("wea", 32'(wea_weight), 32'(e_wea));
      if (e_wea != '0) begin
        chk("addr", 32'(addr_weight), 32'(e_addr));
        chk("din", 32'(din_weight), 32'(e_din));
      end
      chk("ack", 32'(weight_ack), 32'(e_ack));
      chk("s_ready", 32'(s_ready), 32'(m_loading));
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("err_len", 32'(err_len), 32'(m_err));
`ifdef WEIGHT_PINGPONG_EN
      chk("active_half", 32'(active_half), 32'(m_active));
`endif
      if (wea_weight != '0) begin
        wr_count++;
        for (int b = 0; b < int'(DIM); b++)
          if (wea_weight[b]) dut_mem[b][addr_weight] = din_weight;
      end
      if (weight_ack) ack_count++;
      if (s_ready) rdy_count++;
    end
  end

  function automatic logic pick_valid(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  function automatic logic [DW-1:0] data_for(input int mode, input int n);
    if (mode == 2) return DW'($urandom);
    return DW'(n);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wea0"}, 32'(wea_weight), 0);
    chk({tag, "_ack0"}, 32'(weight_ack), 0);
    chk({tag, "_rdy0"}, 32'(s_ready), 0);
    chk({tag, "_busy0"}, 32'(busy), 0);
    chk({tag, "_err0"}, 32'(err_len), 0);
    chk({tag, "_addr0"}, 32'(addr_weight), 0);
    chk({tag, "_din0"}, 32'(din_weight), 0);
  endtask

  // One request: stream beats until ack (or abort), then hold req for 'hold' cycles
  task automatic run_req(input int k, input int ch, input int mode,
                         input int drop_at, input int abort_at, input int hold);
    int cnt = 0;
    int budget = 0;
    bit got = 0;
    bit beat;
    @(posedge clk); #1;
    kernel_size    = 5'(k);
    input_channels = 10'(ch);
    weight_req     = 1'b1;
    s_valid        = pick_valid(mode, 0);
    s_data         = data_for(mode, 0);
    while (!got && budget < 20000) begin
      @(posedge clk);
      beat = s_valid && s_ready;
      #1;
      budget++;
      if (beat) begin
        cnt++;
        last_beat_cyc = cyc - 1;
      end
      if (weight_ack) begin
        got = 1;
        ack_cyc = cyc;
      end
      if (abort_at >= 0 && cnt == abort_at) begin
        rst_n = 1'b0;
        break;
      end
      if (cnt == drop_at) weight_req = 1'b0;
      s_valid = pick_valid(mode, budget);
      s_data  = data_for(mode, cnt);
    end
    if (abort_at >= 0) begin
      #1;
      chk_all_zero("abort");
      weight_req = 1'b0;
      s_valid    = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      return;
    end
    if (!got) chk("ack_timeout", 0, 1);
    s_valid = 1'b0;
    repeat (hold) @(posedge clk);
    #1 weight_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  int w0, a0, r0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 3x2 filter, continuous stream, data = beat index
    w0 = wr_count; a0 = ack_count;
    run_req(3, 2, 0, -1, -1, 2);
    chk("t1_writes", 32'(wr_count - w0), 96);
    chk("t1_acks", 32'(ack_count - a0), 1);
    chk("t1_latency", 32'(ack_cyc - last_beat_cyc), 2);
    chk("t1_b0_a0", 32'(dut_mem[0][0]), 0);
    chk("t1_b5_a3", 32'(dut_mem[5][3]), 53);
    chk("t1_b15_a5", 32'(dut_mem[15][5]), 95);

    // Same load with a 1/0 valid pattern
    dut_mem[5][3] = 16'hDEAD; dut_mem[15][5] = 16'hDEAD;
    w0 = wr_count; a0 = ack_count;
    run_req(3, 2, 1, -1, -1, 0);
    chk("t2_writes", 32'(wr_count - w0), 96);
    chk("t2_acks", 32'(ack_count - a0), 1);
    chk("t2_b5_a3", 32'(dut_mem[5][3]), 53);
    chk("t2_b15_a5", 32'(dut_mem[15][5]), 95);

    // Zero-length request
    w0 = wr_count; a0 = ack_count; r0 = rdy_count;
    run_req(0, 2, 0, -1, -1, 1);
    chk("t3_writes", 32'(wr_count - w0), 0);
    chk("t3_ready", 32'(rdy_count - r0), 0);
    chk("t3_acks", 32'(ack_count - a0), 1);

    // Oversized request, then a valid one clears err_len
    w0 = wr_count; a0 = ack_count;
    run_req(31, 40, 0, -1, -1, 1);
    chk("t4_writes", 32'(wr_count - w0), 0);
    chk("t4_acks", 32'(ack_count - a0), 1);
    chk("t4_err", 32'(err_len), 1);
    run_req(1, 1, 0, -1, -1, 0);
    chk("t4_err_clr", 32'(err_len), 0);

    // Reset at beat 40, then a clean reload
    a0 = ack_count;
    run_req(3, 2, 0, -1, 40, 0);
    chk("t5_no_ack", 32'(ack_count - a0), 0);
    dut_mem[15][5] = 16'hDEAD;
    w0 = wr_count;
    run_req(3, 2, 0, -1, -1, 0);
    chk("t5_writes", 32'(wr_count - w0), 96);
    chk("t5_b15_a5", 32'(dut_mem[15][5]), 95);

    // Request withdrawn mid-load still completes
    w0 = wr_count; a0 = ack_count;
    run_req(2, 3, 2, 5, -1, 0);
    chk("t6_writes", 32'(wr_count - w0), 96);
    chk("t6_acks", 32'(ack_count - a0), 1);

    // Randomized requests
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 7) == 0)
        run_req(31, 40, 2, -1, -1, int'($urandom_range(0, 3)));
      else
        run_req(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0) ? 7 : -1, -1, int'($urandom_range(0, 3)));
    end

`ifdef WEIGHT_PINGPONG_EN
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dut_mem[3][5] = '0; dut_mem[3][517] = '0;
    run_req(3, 2, 0, -1, -1, 0);
    chk("pp_half_first", 32'(active_half), 0);
    chk("pp_first_b3_a5", 32'(dut_mem[3][5]), 83);
    run_req(3, 2, 0, -1, -1, 0);
    chk("pp_half_second", 32'(active_half), 1);
    chk("pp_second_b3_a517", 32'(dut_mem[3][517]), 83);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
